// File: rtl/int_pe_simd.sv
// int_pe_simd: output-stationary multi-lane INT processing element.
// Forwards packed operands right/down with their control, accumulates a
// LANES-wide dot product into a wide accumulator and shifts partial sums
// down a drain chain. Sticky overflow flag.
// Optional feature: define INT_PE_SAT_EN to clamp the accumulator on
// overflow instead of wrapping.
module int_pe_simd #(
    parameter int WORD_SIZE = 4,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode_in,
    input  logic                         signed_in,
    input  logic                         valid_in,
    input  logic [LANES*WORD_SIZE-1:0]   left_in,
    input  logic [LANES*WORD_SIZE-1:0]   top_in,
    input  logic [ACC_WIDTH-1:0]         psum_in,
    input  logic                         psum_valid_in,
    output logic [LANES*WORD_SIZE-1:0]   right_out,
    output logic [LANES*WORD_SIZE-1:0]   bottom_out,
    output logic                         valid_out,
    output logic [1:0]                   mode_out,
    output logic                         signed_out,
    output logic [ACC_WIDTH-1:0]         psum_out,
    output logic                         psum_valid_out,
    output logic                         ovf_out
);

    localparam int OPW = LANES * WORD_SIZE;
    localparam int PW  = 2 * WORD_SIZE;
    localparam int MSB = ACC_WIDTH - 1;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_MAC   = 2'b01,
        MODE_DRAIN = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    logic [OPW-1:0]       left_q;
    logic [OPW-1:0]       top_q;
    logic                 valid_q;
    logic                 signed_q;
    mode_t                mode_q;

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 psum_valid_q;
    logic                 ovf_q;

    logic [ACC_WIDTH-1:0] dot;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] mac_result;
    logic                 mac_ovf;

    // Operand stage: capture operands and control so the wavefront stays aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q   <= '0;
            top_q    <= '0;
            valid_q  <= 1'b0;
            signed_q <= 1'b0;
            mode_q   <= MODE_HOLD;
        end else begin
            left_q   <= left_in;
            top_q    <= top_in;
            valid_q  <= valid_in;
            signed_q <= signed_in;
            mode_q   <= mode_t'(mode_in);
        end
    end

    // Dot product: per-lane products are exact in 2*WORD_SIZE bits, then widened
    always_comb begin
        logic [WORD_SIZE-1:0] a_lane;
        logic [WORD_SIZE-1:0] b_lane;
        logic [PW-1:0]        a_ext;
        logic [PW-1:0]        b_ext;
        logic [PW-1:0]        prod;
        dot    = '0;
        a_lane = '0;
        b_lane = '0;
        a_ext  = '0;
        b_ext  = '0;
        prod   = '0;
        for (int i = 0; i < LANES; i++) begin
            a_lane = left_q[i*WORD_SIZE +: WORD_SIZE];
            b_lane = top_q[i*WORD_SIZE +: WORD_SIZE];
            if (signed_q) begin
                a_ext = PW'(signed'(a_lane));
                b_ext = PW'(signed'(b_lane));
            end else begin
                a_ext = PW'(a_lane);
                b_ext = PW'(b_lane);
            end
            prod = a_ext * b_ext;
            if (signed_q) begin
                dot = dot + ACC_WIDTH'(signed'(prod));
            end else begin
                dot = dot + ACC_WIDTH'(prod);
            end
        end
    end

    // Accumulate with overflow detection; clamp instead of wrap when saturation is built in
    always_comb begin
        sum_ext    = {1'b0, acc_q} + {1'b0, dot};
        mac_result = sum_ext[ACC_WIDTH-1:0];
        if (signed_q) begin
            mac_ovf = (acc_q[MSB] == dot[MSB]) && (sum_ext[MSB] != acc_q[MSB]);
        end else begin
            mac_ovf = sum_ext[ACC_WIDTH];
        end
`ifdef INT_PE_SAT_EN
        if (mac_ovf) begin
            if (signed_q) begin
                mac_result = acc_q[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                mac_result = '1;
            end
        end
`endif
    end

    // Accumulator stage: action selected by the mode that travelled with the operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (mode_q)
                MODE_MAC: begin
                    if (valid_q) begin
                        acc_q        <= mac_result;
                        psum_valid_q <= 1'b1;
                        if (mac_ovf) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                MODE_DRAIN: begin
                    acc_q        <= psum_in;
                    psum_valid_q <= psum_valid_in;
                end
                MODE_CLEAR: begin
                    acc_q        <= '0;
                    psum_valid_q <= 1'b0;
                    ovf_q        <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign right_out      = left_q;
    assign bottom_out     = top_q;
    assign valid_out      = valid_q;
    assign mode_out       = mode_q;
    assign signed_out     = signed_q;
    assign psum_out       = acc_q;
    assign psum_valid_out = psum_valid_q;
    assign ovf_out        = ovf_q;

endmodule

// File: tb/tb_int_pe_simd.sv
// tb_int_pe_simd: randomized and directed checks of int_pe_simd against an
// arithmetic reference model. A second, 8-bit-accumulator instance covers
// overflow (wrap or clamp depending on INT_PE_SAT_EN).
module tb_int_pe_simd;

    localparam int W  = 4;
    localparam int L  = 2;
    localparam int AW = 24;

    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] MAC   = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic          clk;
    logic          rst;
    logic [1:0]    mode_in;
    logic          signed_in;
    logic          valid_in;
    logic [L*W-1:0] left_in;
    logic [L*W-1:0] top_in;
    logic [AW-1:0] psum_in;
    logic          psum_valid_in;

    logic [L*W-1:0] right_out;
    logic [L*W-1:0] bottom_out;
    logic          valid_out;
    logic [1:0]    mode_out;
    logic          signed_out;
    logic [AW-1:0] psum_out;
    logic          psum_valid_out;
    logic          ovf_out;

    logic [L*W-1:0] s_right;
    logic [L*W-1:0] s_bottom;
    logic          s_valid;
    logic [1:0]    s_mode;
    logic          s_signed;
    logic [7:0]    s_psum;
    logic          s_psum_valid;
    logic          s_ovf;

    int testsRun;
    int testsFailed;

    int_pe_simd #(.WORD_SIZE(W), .LANES(L), .ACC_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .signed_in(signed_in),
        .valid_in(valid_in), .left_in(left_in), .top_in(top_in),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .right_out(right_out), .bottom_out(bottom_out), .valid_out(valid_out),
        .mode_out(mode_out), .signed_out(signed_out), .psum_out(psum_out),
        .psum_valid_out(psum_valid_out), .ovf_out(ovf_out)
    );

    int_pe_simd #(.WORD_SIZE(W), .LANES(L), .ACC_WIDTH(8)) u_small (
        .clk(clk), .rst(rst), .mode_in(mode_in), .signed_in(signed_in),
        .valid_in(valid_in), .left_in(left_in), .top_in(top_in),
        .psum_in(psum_in[7:0]), .psum_valid_in(psum_valid_in),
        .right_out(s_right), .bottom_out(s_bottom), .valid_out(s_valid),
        .mode_out(s_mode), .signed_out(s_signed), .psum_out(s_psum),
        .psum_valid_out(s_psum_valid), .ovf_out(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the operand stage holds, plus the accumulator
    typedef struct {
        logic [1:0]     mode;
        bit             sgn;
        bit             valid;
        logic [L*W-1:0] left;
        logic [L*W-1:0] top;
    } stage_t;

    stage_t stg;
    longint mAcc;
    bit     mPv;
    bit     mOvf;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic longint laneVal(input logic [L*W-1:0] word, input int i, input bit sgn);
        logic [W-1:0] x;
        x = W'(word >> (i * W));
        if (sgn && x[W-1]) return longint'(x) - (64'sd1 <<< W);
        return longint'(x);
    endfunction

    function automatic logic [L*W-1:0] pk(input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        return {bv[W-1:0], av[W-1:0]};
    endfunction

    task automatic modelReset();
        stg.mode  = HOLD;
        stg.sgn   = 1'b0;
        stg.valid = 1'b0;
        stg.left  = '0;
        stg.top   = '0;
        mAcc      = 0;
        mPv       = 1'b0;
        mOvf      = 1'b0;
    endtask

    // One clock edge of the model: act on the staged control, then stage the new inputs
    task automatic modelEdge();
        longint dot;
        longint s;
        longint lo;
        longint hi;
        longint modv;
        modv = 64'sd1 <<< AW;
        case (stg.mode)
            MAC: begin
                if (stg.valid) begin
                    dot = 0;
                    for (int i = 0; i < L; i++) begin
                        dot += laneVal(stg.left, i, stg.sgn) * laneVal(stg.top, i, stg.sgn);
                    end
                    if (stg.sgn) begin
                        s  = (mAcc >= (modv >>> 1)) ? mAcc - modv : mAcc;
                        s  = s + dot;
                        lo = -(modv >>> 1);
                        hi = (modv >>> 1) - 1;
                    end else begin
                        s  = mAcc + dot;
                        lo = 0;
                        hi = modv - 1;
                    end
                    if (s > hi || s < lo) begin
                        mOvf = 1'b1;
`ifdef INT_PE_SAT_EN
                        s = (s > hi) ? hi : lo;
`endif
                    end
                    mAcc = ((s % modv) + modv) % modv;
                    mPv  = 1'b1;
                end
            end
            DRAIN: begin
                mAcc = longint'(psum_in);
                mPv  = psum_valid_in;
            end
            CLEAR: begin
                mAcc = 0;
                mPv  = 1'b0;
                mOvf = 1'b0;
            end
            default: begin
            end
        endcase
        stg.mode  = mode_in;
        stg.sgn   = signed_in;
        stg.valid = valid_in;
        stg.left  = left_in;
        stg.top   = top_in;
    endtask

    task automatic checkAgainstModel();
        checkOutput("right_out", 32'(right_out), 32'(stg.left));
        checkOutput("bottom_out", 32'(bottom_out), 32'(stg.top));
        checkOutput("valid_out", 32'(valid_out), 32'(stg.valid));
        checkOutput("mode_out", 32'(mode_out), 32'(stg.mode));
        checkOutput("signed_out", 32'(signed_out), 32'(stg.sgn));
        checkOutput("psum_out", 32'(psum_out), 32'(mAcc));
        checkOutput("psum_valid_out", 32'(psum_valid_out), 32'(mPv));
        checkOutput("ovf_out", 32'(ovf_out), 32'(mOvf));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare off-edge
    task automatic applyStimulus(input logic [1:0] m, input bit s, input bit v,
                                 input logic [L*W-1:0] l, input logic [L*W-1:0] t,
                                 input logic [AW-1:0] p, input bit pv);
        mode_in       = m;
        signed_in     = s;
        valid_in      = v;
        left_in       = l;
        top_in        = t;
        psum_in       = p;
        psum_valid_in = pv;
        @(posedge clk);
        modelEdge();
        #1;
        checkAgainstModel();
    endtask

    task automatic randomInputs();
        mode_in       = 2'($urandom);
        signed_in     = 1'($urandom);
        valid_in      = 1'($urandom);
        left_in       = (L*W)'($urandom);
        top_in        = (L*W)'($urandom);
        psum_in       = AW'($urandom);
        psum_valid_in = 1'($urandom);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_psum"}, 32'(psum_out), 32'd0);
        checkOutput({tag, "_pvalid"}, 32'(psum_valid_out), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(ovf_out), 32'd0);
        checkOutput({tag, "_right"}, 32'(right_out), 32'd0);
        checkOutput({tag, "_bottom"}, 32'(bottom_out), 32'd0);
        checkOutput({tag, "_valid"}, 32'(valid_out), 32'd0);
        checkOutput({tag, "_mode"}, 32'(mode_out), 32'd0);
        checkOutput({tag, "_signed"}, 32'(signed_out), 32'd0);
    endtask

    // Assert reset between edges, expect immediate clearing, hold with toggling inputs
    task automatic doReset(input int cycles);
        #2;
        rst = 1'b1;
        randomInputs();
        #1;
        checkAllZero("rst_async");
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            randomInputs();
            @(posedge clk);
            #1;
            checkAllZero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        randomInputs();
        modelReset();
        #1;
        doReset(3);

        // Signed MAC: {-8,7}.{-8,7} = 113 per cycle, three cycles
        applyStimulus(CLEAR, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(MAC, 1'b1, 1'b1, pk(-8, 7), pk(-8, 7), '0, 1'b0);
        end
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("signed_mac_339", 32'(psum_out), 32'd339);
        checkOutput("signed_mac_ovf", 32'(ovf_out), 32'd0);

        // Unsigned and signed interpretation of the same bit patterns
        applyStimulus(CLEAR, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(MAC, 1'b0, 1'b1, pk(15, 15), pk(15, 15), '0, 1'b0);
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("unsigned_mac_450", 32'(psum_out), 32'd450);
        applyStimulus(CLEAR, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(MAC, 1'b1, 1'b1, pk(15, 15), pk(15, 15), '0, 1'b0);
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("signed_mac_2", 32'(psum_out), 32'd2);

        // Valid gaps: only valid cycles accumulate; forwarding lags by one cycle
        applyStimulus(CLEAR, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(MAC, 1'b0, 1'b1, pk(1, 1), pk(2, 2), '0, 1'b0);
        applyStimulus(MAC, 1'b0, 1'b0, pk(1, 1), pk(2, 2), '0, 1'b0);
        checkOutput("gap_valid_lag0", 32'(valid_out), 32'd0);
        applyStimulus(MAC, 1'b0, 1'b1, pk(1, 1), pk(2, 2), '0, 1'b0);
        checkOutput("gap_valid_lag1", 32'(valid_out), 32'd1);
        checkOutput("gap_right_lag", 32'(right_out), 32'(pk(1, 1)));
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("gap_sum_8", 32'(psum_out), 32'd8);

        // Drain chain: acc takes psum_in one edge after DRAIN is staged
        applyStimulus(DRAIN, 1'b0, 1'b0, '0, '0, 24'h00ABCD, 1'b1);
        checkOutput("drain_before", 32'(psum_out), 32'd8);
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, 24'h00ABCD, 1'b1);
        checkOutput("drain_psum", 32'(psum_out), 32'h00ABCD);
        checkOutput("drain_pvalid", 32'(psum_valid_out), 32'd1);

        // Overflow on the 8-bit instance: 98 + 98 exceeds signed 8-bit range
        applyStimulus(CLEAR, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(MAC, 1'b1, 1'b1, pk(7, 7), pk(7, 7), '0, 1'b0);
        applyStimulus(MAC, 1'b1, 1'b1, pk(7, 7), pk(7, 7), '0, 1'b0);
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, '0, 1'b0);
`ifdef INT_PE_SAT_EN
        checkOutput("ovf8_psum", 32'(s_psum), 32'h7F);
`else
        checkOutput("ovf8_psum", 32'(s_psum), 32'hC4);
`endif
        checkOutput("ovf8_flag", 32'(s_ovf), 32'd1);
        checkOutput("ovf24_none", 32'(psum_out), 32'd196);
        applyStimulus(CLEAR, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(HOLD, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("ovf8_clear_psum", 32'(s_psum), 32'd0);
        checkOutput("ovf8_clear_flag", 32'(s_ovf), 32'd0);

        // Randomized traffic, mostly MAC, with a reset dropped in mid-accumulation
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [1:0] m;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      m = MAC;
            else if (r == 7) m = DRAIN;
            else if (r == 8) m = CLEAR;
            else             m = HOLD;
            applyStimulus(m, 1'($urandom), ($urandom_range(0, 3) != 0),
                          (L*W)'($urandom), (L*W)'($urandom),
                          AW'($urandom), 1'($urandom));
            if (n == 150) begin
                doReset(2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/int_pe_simd.md
# int_pe_simd

Parametrised output-stationary INT processing element for the systolic MAC array, successor to the single-lane INT4 PE. Each cycle it forwards packed operands right and down. It accumulates a LANES-wide signed or unsigned dot product into a wide accumulator, and shifts partial sums down a drain chain. Control (mode, signedness, valid) travels with the operands so that a wavefront stays coherent across the array.

## Interface
- WORD_SIZE, 4, bits per operand lane
- LANES, 2, operand pairs per cycle; must be ≥1
- ACC_WIDTH, 24, accumulator and partial-sum width; must be ≥ 2*WORD_SIZE+clog2(LANES)+1

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mode_in  in  2  00 HOLD, 01 MAC, 10 DRAIN, 11 CLEAR
- signed_in  in  1  1 = operands two's complement, 0 = unsigned
- valid_in  in  1  left_in/top_in carry valid operands
- left_in  in  LANES*WORD_SIZE  packed operands; lane i at bits [i*WORD_SIZE +: WORD_SIZE]
- top_in  in  LANES*WORD_SIZE  packed operands, same packing
- psum_in  in  ACC_WIDTH  partial sum from the PE above (drain chain)
- psum_valid_in  in  1  psum_in valid
- right_out  out  LANES*WORD_SIZE  registered left_in
- bottom_out  out  LANES*WORD_SIZE  registered top_in
- valid_out  out  1  registered valid_in
- mode_out  out  2  registered mode_in
- signed_out  out  1  registered signed_in
- psum_out  out  ACC_WIDTH  accumulator register
- psum_valid_out  out  1  accumulator holds drained or completed data
- ovf_out  out  1  sticky overflow flag

## Operation
- Stage 1 (operand regs): every edge captures left_in, top_in, valid_in, mode_in and signed_in into *_q. The registers drive right_out, bottom_out, valid_out, mode_out and signed_out directly.
- Stage 2 (accumulator): on each edge, the action is chosen by mode_q:
  - HOLD: acc, psum_valid and ovf unchanged.
  - MAC with valid_q=1: acc ← acc + dot. psum_valid ← 1.
  - MAC with valid_q=0: unchanged.
  - DRAIN: acc ← psum_in. psum_valid ← psum_valid_in. ovf unchanged.
  - CLEAR: acc ← 0. psum_valid ← 0. ovf ← 0.
- dot = Σ over lanes of left_q[i]*top_q[i]. Each lane is extended to 2*WORD_SIZE bits, sign-extended if signed_q=1 and zero-extended otherwise. The sum is then extended the same way to ACC_WIDTH.
- Overflow detection:
  - Signed mode: operand signs of acc and dot are equal and the result sign differs.
  - Unsigned mode: carry out of bit ACC_WIDTH-1.
  - On overflow, ovf_out ← 1, and it stays 1 until CLEAR or rst.
- psum_out = acc register. psum_valid_out = psum_valid register.

## Timing
- Reset value of every output is 0, with mode_out = HOLD.
- Operand forwarding latency: 1 cycle, input to right_out/bottom_out/valid_out.
- MAC latency: operands presented before edge N are added into acc at edge N+1 and are visible on psum_out after edge N+1.
- DRAIN: mode sampled at edge N. At edge N+1, acc captures the psum_in present before edge N+1.
- Back-to-back mode changes are legal every cycle, with no bubbles.
- rst asserted mid-accumulation clears all state immediately. The first edge after deassertion samples fresh inputs.

## Configuration
- INT_PE_SAT_EN defined: on overflow, acc clamps instead of wrapping, and ovf_out is still set.
  - Signed clamp: 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned clamp: 2^ACC_WIDTH-1.
- INT_PE_SAT_EN undefined: acc wraps modulo 2^ACC_WIDTH, and ovf_out is set on overflow.

## Test plan
Defaults are WORD_SIZE=4, LANES=2, ACC_WIDTH=24 unless stated.
- Reset: assert rst with random inputs toggling → all outputs 0 and mode_out=00; hold for 3 cycles.
- Signed MAC: CLEAR, then 3 cycles of MAC, signed=1, valid=1, left={-8,7}, top={-8,7} → psum_out=339 two cycles after the last operand; ovf_out=0.
- Unsigned MAC: CLEAR, then 1 MAC with signed=0, left={15,15}, top={15,15} → psum_out=450. The same operands with signed=1 → psum_out=2.
- Valid gaps: MAC with valid pattern 1,0,1 and operands {1,1}×{2,2} each cycle → psum_out=8. right_out/valid_out track the inputs with exactly 1-cycle lag.
- Drain chain: after a MAC result, DRAIN with psum_in=0x00ABCD and psum_valid_in=1 → psum_out=0x00ABCD and psum_valid_out=1 at the expected edge.
- Overflow, ACC_WIDTH=8, signed: accumulate {7,7}×{7,7} (98 per cycle) twice.
  - Without INT_PE_SAT_EN: psum_out=196 mod 256 = 0xC4 (−60), ovf_out=1.
  - With INT_PE_SAT_EN: psum_out=127, ovf_out=1.
  - A following CLEAR → psum_out=0, ovf_out=0.
